ac_multi_pe_dispatcher: RTL
===========================

Name: ac_multi_pe_dispatcher

Overview:
- Access-control successor that feeds N_PE bicubic processing elements in parallel instead of one.
- Accepts the source AXI-Stream and distributes beats round-robin to the PE read ports.
- Gathers PE write data in the same round-robin order into one registered AXI-Stream output, with frame start/end handshakes to the config register file.
- Sits between the CRF / stream ports and an array of bicubic_processing_element instances.

Parameters:
N_PE, 4, number of processing elements (>=1, power of 2 not required)
AXISIN_DATA_WIDTH, 32, input stream / PE read data width (equal to UPSP_RDDATA_WIDTH)
AXISOUT_DATA_WIDTH, 32, output stream / PE write data width (equal to UPSP_WRTDATA_WIDTH)
IN_BEATS, 129600, input beats per frame
OUT_GROUP, 16, output beats taken from one PE before advancing to the next PE

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
crf_ac_UPSTART  in  1  frame start pulse
crf_ac_abort  in  1  synchronous abort pulse
ac_crf_processing  out  1  high while a frame is active
ac_crf_UPEND  out  1  one-cycle frame-done pulse
ac_crf_err_tlast  out  1  sticky tlast-mismatch flag (optional feature)
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat ready
s_axis_tdata  in  AXISIN_DATA_WIDTH  input pixel data
s_axis_tlast  in  1  input end of frame
ac_upsp_rvalid  out  N_PE  per-PE read valid
ac_upsp_rdata  out  N_PE*AXISIN_DATA_WIDTH  per-PE read data, PE i in slice i
upsp_ac_rready  in  N_PE  per-PE read ready
upsp_ac_wvalid  in  N_PE  per-PE write valid
upsp_ac_wdata  in  N_PE*AXISOUT_DATA_WIDTH  per-PE write data
ac_upsp_wready  out  N_PE  per-PE write ready
m_axis_tvalid  out  1  output valid (registered)
m_axis_tready  in  1  output ready
m_axis_tdata  out  AXISOUT_DATA_WIDTH  output data (registered)
m_axis_tlast  out  1  last beat of frame
m_axis_tuser  out  1  first beat of frame (SOF)

Behaviour:
- Clocking and reset: single clock `clk`; `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0. State = IDLE, all counters and selectors 0, err flag 0.
- States:
  - IDLE -> RUN on `crf_ac_UPSTART`. This clears in_cnt, out_cnt, in_sel, out_sel, grp_cnt and err.
  - RUN -> DRAIN when the input beat with in_cnt == IN_BEATS-1 is accepted.
  - DRAIN -> DONE when the output beat with out_cnt == IN_BEATS*OUT_GROUP-1 is accepted downstream (tvalid & tready).
  - DONE -> IDLE after one cycle; `ac_crf_UPEND` = 1 in DONE only.
  - Output collection runs in both RUN and DRAIN.
- `crf_ac_UPSTART` outside IDLE is ignored.
- `crf_ac_abort` in any state: next cycle IDLE, counters cleared, m_axis_tvalid = 0, no UPEND pulse. Abort wins over a simultaneous UPSTART.
- `ac_crf_processing` = (state == RUN) | (state == DRAIN).
- Input path (combinational pass-through, zero latency):
  - In RUN only: `s_axis_tready` = upsp_ac_rready[in_sel]; `ac_upsp_rvalid[in_sel]` = s_axis_tvalid; all other rvalid bits 0.
  - rdata is broadcast to all slices.
  - On accept, in_sel wraps N_PE-1 -> 0 and in_cnt increments.
  - Outside RUN, tready = 0 and all rvalid = 0.
- Output path (one register stage):
  - `ac_upsp_wready[out_sel]` = active & (!m_axis_tvalid | m_axis_tready), where active = RUN | DRAIN.
  - A PE beat is accepted when wvalid[out_sel] & wready[out_sel]. It loads m_axis_tdata/tvalid next cycle, giving 1-cycle latency.
  - grp_cnt counts 0..OUT_GROUP-1. At OUT_GROUP-1 it wraps and out_sel advances, wrapping N_PE-1 -> 0.
  - `m_axis_tuser` = 1 on the beat with out_cnt == 0. `m_axis_tlast` = 1 on the beat with out_cnt == IN_BEATS*OUT_GROUP-1.
  - While m_axis_tvalid & !m_axis_tready, tdata, tlast and tuser hold stable.
  - Full throughput: one beat per cycle when downstream is always ready.
- Counter widths: $clog2 of the max count +1; counters never wrap within a frame.
- Out-of-order PE data is never forwarded: only wready[out_sel] is asserted.

Optional Feature:
- Macro: AC_DISPATCH_TLAST_CHK_EN.
- Enabled: on every accepted input beat, compare s_axis_tlast against (in_cnt == IN_BEATS-1). On mismatch, set `ac_crf_err_tlast`. The flag is sticky until the next accepted UPSTART or reset. The frame continues unaffected.
- Disabled: s_axis_tlast is ignored and `ac_crf_err_tlast` is tied 0.

Test Plan:
- Config N_PE=2, IN_BEATS=8, OUT_GROUP=2. UPSTART, then 8 input beats 0x10..0x17 with all rready=1 -> PE0 receives 0x10,0x12,0x14,0x16 and PE1 receives 0x11,0x13,0x15,0x17; state enters DRAIN after the 8th beat.
- Same frame, each PE returns its beats as wdata = PE_id<<8 | k -> m_axis order is P0k0,P0k1,P1k0,P1k1,... for 16 beats; tuser on beat 0, tlast on beat 15; UPEND pulses exactly 1 cycle after beat 15 is accepted; processing falls the same cycle.
- m_axis_tready toggling 1010..., and upsp_ac_rready[1]=0 for 5 cycles -> no data loss or reorder; tdata stable while stalled; s_axis_tready=0 whenever in_sel=1 during the stall.
- Abort asserted after 5 input beats, simultaneous with UPSTART -> IDLE next cycle, m_axis_tvalid=0, no UPEND; a following clean frame is correct from beat 0.
- rst_n pulled low mid-DRAIN, asynchronously between clock edges -> all outputs 0 immediately; after release, a new UPSTART produces a correct frame.
- With AC_DISPATCH_TLAST_CHK_EN: tlast on beat 6 of 8 -> err=1 and stays 1; next UPSTART clears it. Without the macro, err stays 0 for the same stimulus.

Source files
------------

// File: rtl/ac_multi_pe_dispatcher.sv
// ac_multi_pe_dispatcher: feeds N_PE bicubic processing elements in parallel.
// Input beats are distributed round-robin to the PE read ports. PE write data
// is gathered in groups of OUT_GROUP beats per PE, round-robin, into one
// registered AXI-Stream output. Frame start/end handshake with the CRF.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   crf_ac_UPSTART / crf_ac_abort   frame start pulse / synchronous abort pulse
//   ac_crf_processing / ac_crf_UPEND  frame active / one-cycle frame-done pulse
//   ac_crf_err_tlast                sticky input tlast mismatch flag
//   s_axis_*                        source stream (tvalid/tready/tdata/tlast)
//   ac_upsp_rvalid/rdata, upsp_ac_rready   per-PE read ports (slice i = PE i)
//   upsp_ac_wvalid/wdata, ac_upsp_wready   per-PE write ports (slice i = PE i)
//   m_axis_*                        registered output stream, tuser = SOF
//
// Optional feature macro: AC_DISPATCH_TLAST_CHK_EN (input tlast checking).
module ac_multi_pe_dispatcher #(
   parameter int unsigned N_PE               = 4,
   parameter int unsigned AXISIN_DATA_WIDTH  = 32,
   parameter int unsigned AXISOUT_DATA_WIDTH = 32,
   parameter int unsigned IN_BEATS           = 129600,
   parameter int unsigned OUT_GROUP          = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 crf_ac_UPSTART,
   input  logic                                 crf_ac_abort,
   output logic                                 ac_crf_processing,
   output logic                                 ac_crf_UPEND,
   output logic                                 ac_crf_err_tlast,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic [AXISIN_DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                                 s_axis_tlast,
   output logic [N_PE-1:0]                      ac_upsp_rvalid,
   output logic [N_PE*AXISIN_DATA_WIDTH-1:0]    ac_upsp_rdata,
   input  logic [N_PE-1:0]                      upsp_ac_rready,
   input  logic [N_PE-1:0]                      upsp_ac_wvalid,
   input  logic [N_PE*AXISOUT_DATA_WIDTH-1:0]   upsp_ac_wdata,
   output logic [N_PE-1:0]                      ac_upsp_wready,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [AXISOUT_DATA_WIDTH-1:0]        m_axis_tdata,
   output logic                                 m_axis_tlast,
   output logic                                 m_axis_tuser
);

   localparam int unsigned OUT_BEATS = IN_BEATS * OUT_GROUP;
   localparam int unsigned IN_CNT_W  = $clog2(IN_BEATS) + 1;
   localparam int unsigned OUT_CNT_W = $clog2(OUT_BEATS) + 1;
   localparam int unsigned SEL_W     = (N_PE > 1) ? $clog2(N_PE) : 1;
   localparam int unsigned GRP_W     = (OUT_GROUP > 1) ? $clog2(OUT_GROUP) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]                    state_q,   state_d;
   logic [IN_CNT_W-1:0]           in_cnt_q,  in_cnt_d;
   logic [OUT_CNT_W-1:0]          out_cnt_q, out_cnt_d;
   logic [SEL_W-1:0]              in_sel_q,  in_sel_d;
   logic [SEL_W-1:0]              out_sel_q, out_sel_d;
   logic [GRP_W-1:0]              grp_cnt_q, grp_cnt_d;
   logic                          err_q,     err_d;
   logic                          m_tvalid_q, m_tvalid_d;
   logic [AXISOUT_DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
   logic                          m_tlast_q,  m_tlast_d;
   logic                          m_tuser_q,  m_tuser_d;

   logic                          run_c, active_c, wr_ok_c;
   logic                          sel_rready_c, sel_wvalid_c;
   logic [AXISOUT_DATA_WIDTH-1:0] sel_wdata_c;
   logic                          in_acc_c, w_acc_c;

`ifndef AC_DISPATCH_TLAST_CHK_EN
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
`endif

   assign run_c    = (state_q == ST_RUN);
   assign active_c = run_c | (state_q == ST_DRAIN);
   // Output register can take a new beat when empty or being drained this cycle
   assign wr_ok_c  = active_c & (~m_tvalid_q | m_axis_tready);
   assign in_acc_c = run_c & s_axis_tvalid & sel_rready_c;
   assign w_acc_c  = wr_ok_c & sel_wvalid_c;

   assign ac_crf_processing = active_c;
   assign ac_crf_UPEND      = (state_q == ST_DONE);
   assign ac_crf_err_tlast  = err_q;
   assign m_axis_tvalid     = m_tvalid_q;
   assign m_axis_tdata      = m_tdata_q;
   assign m_axis_tlast      = m_tlast_q;
   assign m_axis_tuser      = m_tuser_q;

   // Per-PE routing: only the selected PE sees valid/ready
   always_comb begin
      sel_rready_c   = 1'b0;
      sel_wvalid_c   = 1'b0;
      sel_wdata_c    = '0;
      ac_upsp_rvalid = '0;
      ac_upsp_wready = '0;
      for (int i = 0; i < int'(N_PE); i++) begin
         if (in_sel_q == SEL_W'(i)) begin
            sel_rready_c      = upsp_ac_rready[i];
            ac_upsp_rvalid[i] = run_c & s_axis_tvalid;
         end
         if (out_sel_q == SEL_W'(i)) begin
            sel_wvalid_c      = upsp_ac_wvalid[i];
            sel_wdata_c       = upsp_ac_wdata[i*AXISOUT_DATA_WIDTH +: AXISOUT_DATA_WIDTH];
            ac_upsp_wready[i] = wr_ok_c;
         end
      end
      s_axis_tready = run_c & sel_rready_c;
      ac_upsp_rdata = run_c ? {N_PE{s_axis_tdata}} : '0;
   end

   // Next-state, counters and output register
   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      in_sel_d   = in_sel_q;
      out_sel_d  = out_sel_q;
      grp_cnt_d  = grp_cnt_q;
      err_d      = err_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tuser_d  = m_tuser_q;

      case (state_q)
         ST_IDLE: begin
            if (crf_ac_UPSTART) begin
               state_d   = ST_RUN;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               in_sel_d  = '0;
               out_sel_d = '0;
               grp_cnt_d = '0;
               err_d     = 1'b0;
            end
         end
         ST_RUN: begin
            if (in_acc_c && in_cnt_q == IN_CNT_W'(IN_BEATS - 1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (m_tvalid_q && m_axis_tready && m_tlast_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (in_acc_c) begin
         in_cnt_d = in_cnt_q + IN_CNT_W'(1);
         in_sel_d = (in_sel_q == SEL_W'(N_PE - 1)) ? '0 : in_sel_q + SEL_W'(1);
`ifdef AC_DISPATCH_TLAST_CHK_EN
         if (s_axis_tlast != (in_cnt_q == IN_CNT_W'(IN_BEATS - 1))) err_d = 1'b1;
`endif
      end

      if (w_acc_c) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = sel_wdata_c;
         m_tuser_d  = (out_cnt_q == '0);
         m_tlast_d  = (out_cnt_q == OUT_CNT_W'(OUT_BEATS - 1));
         out_cnt_d  = out_cnt_q + OUT_CNT_W'(1);
         if (grp_cnt_q == GRP_W'(OUT_GROUP - 1)) begin
            grp_cnt_d = '0;
            out_sel_d = (out_sel_q == SEL_W'(N_PE - 1)) ? '0 : out_sel_q + SEL_W'(1);
         end else begin
            grp_cnt_d = grp_cnt_q + GRP_W'(1);
         end
      end else if (m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end

      // Abort wins over everything, including a coincident UPSTART
      if (crf_ac_abort) begin
         state_d    = ST_IDLE;
         in_cnt_d   = '0;
         out_cnt_d  = '0;
         in_sel_d   = '0;
         out_sel_d  = '0;
         grp_cnt_d  = '0;
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         in_sel_q   <= '0;
         out_sel_q  <= '0;
         grp_cnt_q  <= '0;
         err_q      <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
         m_tuser_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         in_sel_q   <= in_sel_d;
         out_sel_q  <= out_sel_d;
         grp_cnt_q  <= grp_cnt_d;
         err_q      <= err_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tlast_q  <= m_tlast_d;
         m_tuser_q  <= m_tuser_d;
      end
   end

endmodule
